// File: rtl/gpu_regfile.sv
// Host-accessible GPU register file: single-cycle access handshake, range
// error reporting, command doorbell with held cmd_valid, read-only status.
module gpu_regfile #(
    parameter int DW          = 8,
    parameter int AW          = 8,
    parameter int NREGS       = 12,
    parameter int STATUS_ADDR = 10,
    parameter int CMD_ADDR    = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       data_in,
    input  logic                read,
    input  logic                write,
    output logic [DW-1:0]       data_out,
    output logic                do_rdy,
    output logic                err,
    output logic                cmd_valid,
    input  logic                cmd_ack,
    output logic [NREGS*DW-1:0] regs_out
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [DW-1:0]    r_regs [NREGS];
    logic [0:0]       r_state;
    logic             r_rdy_p1;
    logic             r_err_p1;
    logic [DW-1:0]    r_rdata_p1;

    logic             w_rd;
    logic             w_wr;
    logic             w_in_range;
    logic             w_is_status;
    logic             w_is_cmd;
    logic             w_cmd_valid;
    logic             w_cmd_accept;
    logic             w_err;
    logic [DW-1:0]    w_status;
    logic [DW-1:0]    w_rdata;
    logic [NREGS-1:0] w_wr_en;

    // Read wins over write; a write in the same cycle is silently dropped.
    assign w_rd        = read;
    assign w_wr        = write & ~read;
    assign w_in_range  = ({1'b0, addr} < (AW+1)'(NREGS));
    assign w_is_status = (addr == AW'(STATUS_ADDR));
    assign w_is_cmd    = (addr == AW'(CMD_ADDR));
    assign w_cmd_valid = (r_state == ST_PEND);
    assign w_status    = {{(DW-1){1'b0}}, w_cmd_valid};

    always_comb begin
        w_rdata      = '0;
        w_wr_en      = '0;
        w_err        = 1'b0;
        w_cmd_accept = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (addr == AW'(i)) w_rdata = r_regs[i];
        end
        if (w_is_status) w_rdata = w_status;
        if (w_rd) begin
            w_err = ~w_in_range;
        end else if (w_wr) begin
            if (!w_in_range) begin
                w_err = 1'b1;
            end else if (w_is_cmd) begin
                // Doorbell is judged on the pre-edge state, even if cmd_ack arrives now.
                if (r_state == ST_IDLE) begin
                    w_cmd_accept       = 1'b1;
                    w_wr_en[CMD_ADDR]  = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
            end else if (!w_is_status) begin
                for (int i = 0; i < NREGS; i++) begin
                    if (addr == AW'(i)) w_wr_en[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_wr_en[i]) r_regs[i] <= data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_cmd_accept) r_state <= ST_PEND;
                ST_PEND: if (cmd_ack)      r_state <= ST_IDLE;
                default:                   r_state <= ST_IDLE;
            endcase
        end
    end

    // Stage p1: completion pulse, error and read data one cycle after accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_p1   <= 1'b0;
            r_err_p1   <= 1'b0;
            r_rdata_p1 <= '0;
        end else begin
            r_rdy_p1 <= w_rd | w_wr;
            r_err_p1 <= w_err;
            if (w_rd) r_rdata_p1 <= w_rdata;
        end
    end

    assign data_out  = r_rdata_p1;
    assign do_rdy    = r_rdy_p1;
    assign err       = r_err_p1;
    assign cmd_valid = w_cmd_valid;

    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_out[i*DW +: DW] = (i == STATUS_ADDR) ? w_status : r_regs[i];
        end
    end

endmodule

// File: tb/tb_gpu_regfile.sv
// Directed bench for gpu_regfile: hand-computed expectations for accesses,
// doorbell handshake, range errors, read/write priority and async reset.
module tb_gpu_regfile;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int NREGS = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic [AW-1:0]       addr;
    logic [DW-1:0]       data_in;
    logic                read;
    logic                write;
    logic [DW-1:0]       data_out;
    logic                do_rdy;
    logic                err;
    logic                cmd_valid;
    logic                cmd_ack;
    logic [NREGS*DW-1:0] regs_out;

    int n_cmp = 0;
    int n_bad = 0;

    gpu_regfile #(.DW(DW), .AW(AW), .NREGS(NREGS), .STATUS_ADDR(10), .CMD_ADDR(11)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .read(read),
        .write(write), .data_out(data_out), .do_rdy(do_rdy), .err(err),
        .cmd_valid(cmd_valid), .cmd_ack(cmd_ack), .regs_out(regs_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic ack);
        read = rd; write = wr; addr = a; data_in = d; cmd_ack = ack;
    endtask

    // Advance past the next rising edge; outputs then reflect the access just accepted.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] slot(input int i);
        return 32'(regs_out[i*DW +: DW]);
    endfunction

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_rdy",   32'(do_rdy),    0);
        chk("rst_err",   32'(err),       0);
        chk("rst_cmdv",  32'(cmd_valid), 0);
        chk("rst_dout",  32'(data_out),  0);
        chk("rst_regs",  32'(regs_out != '0), 0);
        rst = 1'b0;

        // IDLE + cmd_ack is ignored
        drive(0, 0, 0, 0, 1); tick();
        chk("ack_idle_cmdv", 32'(cmd_valid), 0);
        chk("ack_idle_rdy",  32'(do_rdy),    0);

        drive(0, 1, 3, 8'hA5, 0); tick();
        chk("wr3_rdy",  32'(do_rdy), 1);
        chk("wr3_err",  32'(err),    0);
        chk("wr3_slot", slot(3),     32'hA5);
        drive(1, 0, 3, 0, 0); tick();
        chk("rd3_rdy",  32'(do_rdy),   1);
        chk("rd3_data", 32'(data_out), 32'hA5);
        chk("rd3_err",  32'(err),      0);
        drive(0, 0, 0, 0, 0); tick();
        chk("idle_rdy",  32'(do_rdy),   0);
        chk("idle_hold", 32'(data_out), 32'hA5);

        // Back-to-back: write, read, out-of-range read
        drive(0, 1, 0, 8'h11, 0); tick();
        chk("b2b0_rdy", 32'(do_rdy), 1);
        chk("b2b0_err", 32'(err),    0);
        drive(1, 0, 0, 0, 0); tick();
        chk("b2b1_rdy",  32'(do_rdy),   1);
        chk("b2b1_data", 32'(data_out), 32'h11);
        chk("b2b1_err",  32'(err),      0);
        drive(1, 0, 12, 0, 0); tick();
        chk("b2b2_rdy",  32'(do_rdy),   1);
        chk("b2b2_data", 32'(data_out), 0);
        chk("b2b2_err",  32'(err),      1);
        drive(0, 0, 0, 0, 0); tick();
        chk("b2b3_rdy", 32'(do_rdy), 0);
        chk("b2b3_err", 32'(err),    0);

        // Doorbell
        drive(0, 1, 11, 8'h07, 0); tick();
        chk("db_err",  32'(err),       0);
        chk("db_cmdv", 32'(cmd_valid), 1);
        drive(1, 0, 10, 0, 0); tick();
        chk("st_data", 32'(data_out), 1);
        chk("st_err",  32'(err),      0);
        chk("st_slot", slot(10),      1);
        drive(0, 1, 11, 8'h09, 0); tick();
        chk("db_rej_err",  32'(err),       1);
        chk("db_rej_cmdv", 32'(cmd_valid), 1);
        drive(1, 0, 11, 0, 0); tick();
        chk("db_rd_data", 32'(data_out), 32'h07);
        chk("db_rd_err",  32'(err),      0);
        drive(0, 1, 11, 8'h09, 1); tick();
        chk("db_ackwr_err",  32'(err),       1);
        chk("db_ackwr_cmdv", 32'(cmd_valid), 0);
        chk("db_ackwr_slot", slot(11),       32'h07);
        drive(0, 1, 11, 8'h09, 0); tick();
        chk("db_rewr_err",  32'(err),       0);
        chk("db_rewr_cmdv", 32'(cmd_valid), 1);
        chk("db_rewr_slot", slot(11),       32'h09);

        // Status write ignored without error
        drive(0, 1, 10, 8'hFF, 0); tick();
        chk("st_wr_err",  32'(err), 0);
        chk("st_wr_slot", slot(10), 1);

        // Read priority over write
        drive(0, 1, 5, 8'h22, 0); tick();
        drive(1, 1, 5, 8'hFF, 0); tick();
        chk("rw_rdy",  32'(do_rdy),   1);
        chk("rw_data", 32'(data_out), 32'h22);
        chk("rw_err",  32'(err),      0);
        chk("rw_slot", slot(5),       32'h22);

        // Out-of-range write ignored with error
        drive(0, 1, 200, 8'h33, 0); tick();
        chk("oor_wr_rdy", 32'(do_rdy), 1);
        chk("oor_wr_err", 32'(err),    1);
        chk("oor_wr_s0",  slot(0),     32'h11);

        // Async reset while doorbell pending and a read is in flight
        drive(1, 0, 3, 0, 0);
        #3 rst = 1'b1;
        #1;
        chk("mrst_rdy",  32'(do_rdy),    0);
        chk("mrst_cmdv", 32'(cmd_valid), 0);
        chk("mrst_dout", 32'(data_out),  0);
        chk("mrst_regs", 32'(regs_out != '0), 0);
        tick();
        chk("mrst_edge_rdy", 32'(do_rdy), 0);
        rst = 1'b0;
        drive(1, 0, 3, 0, 0); tick();
        chk("post_rst_rd", 32'(data_out), 0);
        chk("post_rst_rdy", 32'(do_rdy), 1);
        drive(0, 0, 0, 0, 0); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpu_regfile.md
Name: gpu_regfile

Overview:
Parametrised successor to the GPU control register block. It is a host-accessible register file of NREGS words of DW bits with a one-cycle read/write handshake and out-of-range error reporting. It adds a command doorbell register that raises a held cmd_valid towards the GPU core until acknowledged, plus a read-only status register. It sits between the host bus bridge and the GPU core; all register contents are exported flat to the core.

Parameters:
DW, 8, data width of each register and of the host data bus
AW, 8, host address width; NREGS must be <= 2**AW
NREGS, 12, number of implemented registers, addresses 0..NREGS-1
STATUS_ADDR, 10, read-only status register address (< NREGS)
CMD_ADDR, 11, command doorbell register address (< NREGS, != STATUS_ADDR)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
addr  input  AW  host register address
data_in  input  DW  host write data
read  input  1  read request, sampled each clk
write  input  1  write request, sampled each clk
data_out  output  DW  read data, valid while do_rdy=1
do_rdy  output  1  one-cycle completion pulse per accepted access
err  output  1  one-cycle error pulse, coincident with do_rdy
cmd_valid  output  1  command pending towards GPU core
cmd_ack  input  1  core acknowledges command
regs_out  output  NREGS*DW  flat register contents, reg i at bits [i*DW +: DW]

Behaviour:
- Reset (async, rst=1): all registers 0, data_out=0, do_rdy=0, err=0, cmd_valid=0; regs_out=0.
- Access accepted every cycle read|write=1; read has priority when both high (write dropped, no err).
- Latency 1: for an access accepted at edge N, do_rdy=1 (and data_out, err) in cycle N+1, for exactly one cycle; do_rdy=0 in cycles with no accepted access. Back-to-back accesses give one pulse each cycle.
- data_out holds its last value when no read completes; it is undefined-free (never X after reset).
- Normal address (< NREGS, not STATUS/CMD): read returns reg; write stores data_in, visible on regs_out and to reads from the next cycle.
- Read-after-write to the same address in consecutive cycles returns the new value.
- addr >= NREGS: read returns 0 with err=1; write ignored with err=1.
- STATUS_ADDR: read returns {(DW-1)'b0, cmd_valid} sampled at accept; writes ignored, err=0; regs_out slot reflects the same value.
- CMD_ADDR: two-state FSM IDLE (cmd_valid=0) / PENDING (cmd_valid=1).
  - IDLE + write: store data_in, go PENDING (cmd_valid=1 next cycle), err=0.
  - PENDING + write: rejected, register unchanged, err=1, stays PENDING.
  - PENDING + cmd_ack: IDLE next cycle.
  - PENDING + cmd_ack + write in same cycle: write judged on pre-edge state -> rejected, err=1; FSM goes IDLE.
  - IDLE + cmd_ack: ignored.
  - Reads of CMD_ADDR always return the stored value, no err.
- rst asserted mid-operation: immediate clear; in-flight access produces no do_rdy; cmd_valid drops without ack.

Test Plan:
- Reset then write 0xA5 to addr 3, read addr 3 -> do_rdy pulses one cycle after each access, data_out=0xA5, regs_out[31:24]=0xA5, err=0.
- Back-to-back write addr 0=0x11, read addr 0, read addr 12 -> three consecutive do_rdy pulses; data 0x11 then 0x00 with err=1 on the third only.
- Write 0x07 to addr 11 -> cmd_valid=1 next cycle; read addr 10 -> 0x01; write 0x09 to addr 11 -> err=1, read addr 11 still 0x07.
- Pulse cmd_ack while cmd_valid=1 together with write 0x09 to addr 11 -> err=1, cmd_valid=0 next cycle, reg stays 0x07; repeat write -> accepted, cmd_valid=1.
- read=write=1 at addr 5 with data_in 0xFF, reg 5=0x22 -> data_out=0x22, reg 5 unchanged.
- Assert rst while cmd_valid=1 and read in flight -> do_rdy, cmd_valid, data_out, all regs_out immediately 0.
